// File: rtl/tt_um_jleugeri_event_pkg.sv
// Shared definitions for the event processor array: config field
// selectors, per-channel state encoding and the saturating adder.
package tt_um_jleugeri_event_pkg;

  localparam logic [1:0] CFG_GOOD_THR = 2'd0;
  localparam logic [1:0] CFG_BAD_THR  = 2'd1;
  localparam logic [1:0] CFG_DURATION = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ON   = 1'b1
  } ch_state_e;

  // Signed add clamped to the range of a w-bit two's complement value.
  // Operands arrive sign-extended to 32 bits; w is a constant at every
  // call site, so the bounds fold away in synthesis.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    s  = a + b;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_event_channel.sv
// One event channel: good/bad token accumulators, run-time thresholds and
// timeout, IDLE/ON state machine with a tick-gated timer.
module tt_um_jleugeri_event_channel
  import tt_um_jleugeri_event_pkg::*;
#(
  parameter int NEW_TOKENS_BITS = 4,
  parameter int TOKENS_BITS     = 8,
  parameter int DURATION_BITS   = 8,
  parameter int CFG_BITS        = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tick_i,
  input  logic [NEW_TOKENS_BITS-1:0] new_good_i,
  input  logic [NEW_TOKENS_BITS-1:0] new_bad_i,
  input  logic                       cfg_we_i,
  input  logic [1:0]                 cfg_sel_i,
  input  logic [CFG_BITS-1:0]        cfg_data_i,
  output logic                       token_start_o,
  output logic                       token_end_o,
  output logic                       is_on_o
);

  localparam logic [DURATION_BITS-1:0] DUR_ONE = DURATION_BITS'(1);

  logic signed [TOKENS_BITS-1:0] good_acc_q, good_acc_d;
  logic signed [TOKENS_BITS-1:0] bad_acc_q,  bad_acc_d;
  logic [TOKENS_BITS-1:0]        good_thr_q, good_thr_d;
  logic [TOKENS_BITS-1:0]        bad_thr_q,  bad_thr_d;
  logic [DURATION_BITS-1:0]      dur_q,      dur_d;
  logic [DURATION_BITS-1:0]      timer_q,    timer_d;
  logic                          dur_nz_q,   dur_nz_d;
  logic                          start_q,    start_d;
  logic                          end_q,      end_d;
  ch_state_e                     state_q,    state_d;

  // Comparisons are done one bit wider so a threshold with its MSB set is
  // treated as a large positive number rather than a negative one.
  logic signed [TOKENS_BITS:0] good_ext, bad_ext, good_thr_ext, bad_thr_ext;
  logic arm, kill, expired;

  assign good_ext     = {good_acc_q[TOKENS_BITS-1], good_acc_q};
  assign bad_ext      = {bad_acc_q[TOKENS_BITS-1], bad_acc_q};
  assign good_thr_ext = {1'b0, good_thr_q};
  assign bad_thr_ext  = {1'b0, bad_thr_q};

  assign arm     = (good_ext >= good_thr_ext) && (bad_ext <= bad_thr_ext);
  assign kill    = (bad_ext > bad_thr_ext);
  // A zero duration latched at start disables the timeout entirely.
  assign expired = (timer_q == '0) && dur_nz_q;

  // Config field update; the value is visible to the FSM from the next cycle.
  always_comb begin
    good_thr_d = good_thr_q;
    bad_thr_d  = bad_thr_q;
    dur_d      = dur_q;
    if (cfg_we_i) begin
      case (cfg_sel_i)
        CFG_GOOD_THR: good_thr_d = cfg_data_i[TOKENS_BITS-1:0];
        CFG_BAD_THR:  bad_thr_d  = cfg_data_i[TOKENS_BITS-1:0];
        CFG_DURATION: dur_d      = cfg_data_i[DURATION_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Next state: accumulate every cycle, start/end transitions, timer countdown.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dur_nz_d   = dur_nz_q;
    start_d    = 1'b0;
    end_d      = 1'b0;
    good_acc_d = TOKENS_BITS'(sat_add(32'(good_acc_q), 32'($signed(new_good_i)), TOKENS_BITS));
    bad_acc_d  = TOKENS_BITS'(sat_add(32'(bad_acc_q),  32'($signed(new_bad_i)),  TOKENS_BITS));
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_ON;
          start_d  = 1'b1;
          timer_d  = dur_q;
          dur_nz_d = |dur_q;
        end
      end
      ST_ON: begin
        if (kill || expired) begin
          // Ending wipes both accumulators, discarding this cycle's input.
          state_d    = ST_IDLE;
          end_d      = 1'b1;
          good_acc_d = '0;
          bad_acc_d  = '0;
        end else if (tick_i && (timer_q != '0)) begin
          timer_d = timer_q - DUR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      good_acc_q <= '0;
      bad_acc_q  <= '0;
      good_thr_q <= '0;
      bad_thr_q  <= '0;
      dur_q      <= '0;
      timer_q    <= '0;
      dur_nz_q   <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_acc_q <= good_acc_d;
      bad_acc_q  <= bad_acc_d;
      good_thr_q <= good_thr_d;
      bad_thr_q  <= bad_thr_d;
      dur_q      <= dur_d;
      timer_q    <= timer_d;
      dur_nz_q   <= dur_nz_d;
      start_q    <= start_d;
      end_q      <= end_d;
    end
  end

  assign token_start_o = start_q;
  assign token_end_o   = end_q;
  assign is_on_o       = (state_q == ST_ON);

endmodule

// File: rtl/tt_um_jleugeri_event_processor_array.sv
// Array of independent event channels on one clock, sharing a config port
// and a tick enable that provides the slow timebase for all timers.
module tt_um_jleugeri_event_processor_array
  import tt_um_jleugeri_event_pkg::*;
#(
  parameter  int NUM_CHANNELS    = 4,
  parameter  int NEW_TOKENS_BITS = 4,
  parameter  int TOKENS_BITS     = 8,
  parameter  int DURATION_BITS   = 8,
  localparam int CFG_BITS        = (TOKENS_BITS > DURATION_BITS) ? TOKENS_BITS : DURATION_BITS,
  localparam int CH_BITS         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                    clock_fast,
  input  logic                                    reset,
  input  logic                                    tick,
  input  logic [NUM_CHANNELS*NEW_TOKENS_BITS-1:0] new_good_tokens,
  input  logic [NUM_CHANNELS*NEW_TOKENS_BITS-1:0] new_bad_tokens,
  input  logic                                    cfg_we,
  input  logic [CH_BITS-1:0]                      cfg_channel,
  input  logic [1:0]                              cfg_sel,
  input  logic [CFG_BITS-1:0]                     cfg_data,
  output logic [NUM_CHANNELS-1:0]                 token_start,
  output logic [NUM_CHANNELS-1:0]                 token_end,
  output logic [NUM_CHANNELS-1:0]                 is_on,
  output logic                                    any_on
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    // Indices with no matching channel never decode, so such writes drop.
    logic ch_we;
    assign ch_we = cfg_we && (cfg_channel == CH_BITS'(i));

    tt_um_jleugeri_event_channel #(
      .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
      .TOKENS_BITS    (TOKENS_BITS),
      .DURATION_BITS  (DURATION_BITS),
      .CFG_BITS       (CFG_BITS)
    ) u_ch (
      .clk_i        (clock_fast),
      .rst_i        (reset),
      .tick_i       (tick),
      .new_good_i   (new_good_tokens[i*NEW_TOKENS_BITS +: NEW_TOKENS_BITS]),
      .new_bad_i    (new_bad_tokens[i*NEW_TOKENS_BITS +: NEW_TOKENS_BITS]),
      .cfg_we_i     (ch_we),
      .cfg_sel_i    (cfg_sel),
      .cfg_data_i   (cfg_data),
      .token_start_o(token_start[i]),
      .token_end_o  (token_end[i]),
      .is_on_o      (is_on[i])
    );
  end

  assign any_on = |is_on;

endmodule

// File: tb/tb_tt_um_jleugeri_event_processor_array.sv
// Bench for the event processor array: a basic-fire vector table, directed
// corner sequences and a randomized run against a per-channel integer model.
module tb_tt_um_jleugeri_event_processor_array;
  localparam int NCH  = 4;
  localparam int NTB  = 4;
  localparam int TMAX = 127;
  localparam int TMIN = -128;

  logic clock_fast = 1'b0;
  logic reset, tick, cfg_we;
  logic [1:0] cfg_channel, cfg_sel;
  logic [7:0] cfg_data;
  logic [NCH*NTB-1:0] new_good_tokens, new_bad_tokens;
  logic [NCH-1:0] token_start, token_end, is_on;
  logic any_on;
  int in_good[NCH];
  int in_bad[NCH];

  always #5 clock_fast = ~clock_fast;

  always_comb begin
    new_good_tokens = '0;
    new_bad_tokens  = '0;
    for (int i = 0; i < NCH; i++) begin
      new_good_tokens[i*NTB +: NTB] = in_good[i][NTB-1:0];
      new_bad_tokens[i*NTB +: NTB]  = in_bad[i][NTB-1:0];
    end
  end

  tt_um_jleugeri_event_processor_array #(
    .NUM_CHANNELS(NCH), .NEW_TOKENS_BITS(NTB), .TOKENS_BITS(8), .DURATION_BITS(8)
  ) dut (
    .clock_fast(clock_fast), .reset(reset), .tick(tick),
    .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
    .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .token_start(token_start), .token_end(token_end), .is_on(is_on), .any_on(any_on)
  );

  // Reference model: plain integers per channel.
  int m_g[NCH], m_b[NCH], m_gthr[NCH], m_bthr[NCH], m_dur[NCH], m_timer[NCH];
  bit m_on[NCH], m_dnz[NCH], m_st[NCH], m_en[NCH];
  int nvec = 0, nmis = 0, cyc = 0;

  function automatic int clamp(input int v);
    if (v > TMAX) return TMAX;
    if (v < TMIN) return TMIN;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_g[i] = 0; m_b[i] = 0; m_gthr[i] = 0; m_bthr[i] = 0; m_dur[i] = 0;
      m_timer[i] = 0; m_on[i] = 0; m_dnz[i] = 0; m_st[i] = 0; m_en[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit arm, kill, expd, ending;
      arm    = (m_g[i] >= m_gthr[i]) && (m_b[i] <= m_bthr[i]);
      kill   = (m_b[i] > m_bthr[i]);
      expd   = (m_timer[i] == 0) && m_dnz[i];
      ending = 0;
      m_st[i] = 0;
      m_en[i] = 0;
      if (!m_on[i]) begin
        if (arm) begin
          m_on[i] = 1; m_st[i] = 1; m_timer[i] = m_dur[i]; m_dnz[i] = (m_dur[i] != 0);
        end
      end else if (kill || expd) begin
        m_on[i] = 0; m_en[i] = 1; ending = 1;
      end else if (tick && m_timer[i] > 0) begin
        m_timer[i]--;
      end
      if (ending) begin
        m_g[i] = 0; m_b[i] = 0;
      end else begin
        m_g[i] = clamp(m_g[i] + in_good[i]);
        m_b[i] = clamp(m_b[i] + in_bad[i]);
      end
      if (cfg_we && int'(cfg_channel) == i) begin
        case (int'(cfg_sel))
          0: m_gthr[i] = int'(cfg_data);
          1: m_bthr[i] = int'(cfg_data);
          2: m_dur[i]  = int'(cfg_data);
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: DUT and model advance on the same edge, outputs compared 1ns later.
  task automatic cycle();
    logic [NCH-1:0] es, ee, eo;
    @(posedge clock_fast);
    model_step();
    cyc++;
    #1;
    for (int i = 0; i < NCH; i++) begin
      es[i] = m_st[i]; ee[i] = m_en[i]; eo[i] = m_on[i];
    end
    check("model_start", 32'(token_start), 32'(es));
    check("model_end",   32'(token_end),   32'(ee));
    check("model_is_on", 32'(is_on),       32'(eo));
    check("model_any_on", 32'(any_on),     32'(|eo));
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_channel = 2'(ch); cfg_sel = 2'(sel); cfg_data = 8'(data);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_is_on",  32'(is_on), 0);
    check("rst_mid_any_on", 32'(any_on), 0);
    check("rst_mid_end",    32'(token_end), 0);
    @(posedge clock_fast);
    #1;
    check("rst_hold_end",   32'(token_end), 0);
    check("rst_hold_start", 32'(token_start), 0);
    @(negedge clock_fast);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit tk;
    int g0;
    logic [NCH-1:0] st;
    logic [NCH-1:0] en;
    logic [NCH-1:0] on;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int s, e, xe, nt, c0, cnt, t;
    bit gap, tk;

    // Basic fire on ch0: thr 3/0, duration 5, tick always high.
    tbl = '{
      '{1'b1, 1, 4'h0, 4'h0, 4'h0},
      '{1'b1, 1, 4'h0, 4'h0, 4'h0},
      '{1'b1, 1, 4'h0, 4'h0, 4'h0},
      '{1'b1, 0, 4'h1, 4'h0, 4'h1},
      '{1'b1, 0, 4'h0, 4'h0, 4'h1},
      '{1'b1, 0, 4'h0, 4'h0, 4'h1},
      '{1'b1, 0, 4'h0, 4'h0, 4'h1},
      '{1'b1, 0, 4'h0, 4'h0, 4'h1},
      '{1'b1, 0, 4'h0, 4'h0, 4'h1},
      '{1'b1, 0, 4'h0, 4'h1, 4'h0},
      '{1'b1, 0, 4'h0, 4'h0, 4'h0},
      '{1'b1, 0, 4'h0, 4'h0, 4'h0}
    };

    reset = 1'b1; tick = 1'b1; cfg_we = 1'b0;
    cfg_channel = '0; cfg_sel = '0; cfg_data = '0;
    for (int i = 0; i < NCH; i++) begin in_good[i] = 0; in_bad[i] = 0; end
    model_reset();
    repeat (2) @(posedge clock_fast);
    #1;
    check("reset_start",  32'(token_start), 0);
    check("reset_end",    32'(token_end), 0);
    check("reset_is_on",  32'(is_on), 0);
    check("reset_any_on", 32'(any_on), 0);
    @(negedge clock_fast);
    reset = 1'b0;

    // Zero thresholds arm every channel at once; park them with an
    // unreachable good threshold and kill them with one bad token.
    for (int i = 0; i < NCH; i++) cfg_write(i, 0, 255);
    for (int i = 0; i < NCH; i++) in_bad[i] = 1;
    cycle();
    for (int i = 0; i < NCH; i++) in_bad[i] = 0;
    repeat (2) cycle();
    check("park_idle", 32'(is_on), 0);
    cfg_write(0, 0, 3);
    cfg_write(0, 2, 5);

    for (int k = 0; k < 12; k++) begin
      tick = tbl[k].tk; in_good[0] = tbl[k].g0;
      cycle();
      check("tbl_start", 32'(token_start), 32'(tbl[k].st));
      check("tbl_end",   32'(token_end),   32'(tbl[k].en));
      check("tbl_is_on", 32'(is_on),       32'(tbl[k].on));
    end
    in_good[0] = 0;

    // Kill on ch1 with no timeout.
    cfg_write(1, 0, 1);
    in_good[1] = 1; cycle(); in_good[1] = 0;
    repeat (3) cycle();
    check("kill_on_before", 32'(is_on[1]), 1);
    in_bad[1] = 1; cycle(); in_bad[1] = 0;
    check("kill_end_early", 32'(token_end[1]), 0);
    cycle();
    check("kill_end_at_2", 32'(token_end[1]), 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("kill_no_refire", 32'(is_on[1]), 0);
    end
    in_good[1] = 1; cycle(); in_good[1] = 0;
    cycle();
    check("kill_refire_cleared", 32'(is_on[1]), 1);
    cfg_write(1, 0, 255);
    in_bad[1] = 1; cycle(); in_bad[1] = 0;
    repeat (2) cycle();

    // Saturation on ch2: 40 x +7 sticks at 127, then 2 x -8 gives 111.
    in_good[2] = 7; repeat (40) cycle();
    in_good[2] = -8; repeat (2) cycle();
    in_good[2] = 0;
    cfg_write(2, 0, 112);
    repeat (2) cycle();
    check("sat_below_112", 32'(is_on[2]), 0);
    cfg_write(2, 0, 111);
    check("sat_thr_pending", 32'(is_on[2]), 0);
    cycle();
    check("sat_at_111", 32'(is_on[2]), 1);
    cfg_write(2, 0, 255);
    in_bad[2] = 1; cycle(); in_bad[2] = 0;
    repeat (2) cycle();

    // Tick gating on ch3: duration 3, tick on every 4th cycle.
    cfg_write(3, 2, 3);
    cfg_write(3, 0, 1);
    s = -1; e = -1; xe = -1; nt = 0; gap = 0;
    for (int k = 0; k < 40; k++) begin
      t = cyc; tk = (t % 4 == 0);
      tick = tk; in_good[3] = (k == 0) ? 1 : 0;
      cycle();
      if (s >= 0 && tk) begin nt++; if (nt == 3) xe = t + 2; end
      if (token_start[3] && s < 0) s = cyc;
      if (token_end[3] && e < 0) e = cyc;
      if (s >= 0 && e < 0 && !is_on[3]) gap = 1;
    end
    tick = 1'b1; in_good[3] = 0;
    check("tick_start_seen", 32'(s >= 0), 1);
    check("tick_end_cycle", 32'(e), 32'(xe));
    check("tick_on_held", 32'(gap), 0);

    // Kill and expiry coincide: one token_end only.
    cfg_write(3, 2, 2);
    c0 = cyc; cnt = 0; s = -1; e = -1;
    for (int k = 0; k < 8; k++) begin
      in_good[3] = (k == 0) ? 1 : 0; in_bad[3] = (k == 3) ? 1 : 0;
      cycle();
      if (token_start[3] && s < 0) s = cyc;
      if (token_end[3]) begin cnt++; e = cyc; end
    end
    in_good[3] = 0; in_bad[3] = 0;
    check("sim_start", 32'(s), 32'(c0 + 2));
    check("sim_end", 32'(e), 32'(c0 + 5));
    check("sim_one_pulse", 32'(cnt), 1);

    // Duration rewrite while ON does not touch the running timer.
    c0 = cyc; s = -1; e = -1;
    for (int k = 0; k < 8; k++) begin
      in_good[3] = (k == 0) ? 1 : 0;
      if (k == 2) begin cfg_we = 1'b1; cfg_channel = 2'd3; cfg_sel = 2'd2; cfg_data = 8'd9; end
      cycle();
      cfg_we = 1'b0;
      if (token_start[3] && s < 0) s = cyc;
      if (token_end[3] && e < 0) e = cyc;
    end
    in_good[3] = 0;
    check("cfg_dur_start", 32'(s), 32'(c0 + 2));
    check("cfg_dur_running", 32'(e - s), 3);
    cfg_write(3, 3, 1);
    s = -1; e = -1;
    for (int k = 0; k < 16; k++) begin
      in_good[3] = (k == 0) ? 1 : 0;
      cycle();
      if (token_start[3] && s < 0) s = cyc;
      if (token_end[3] && e < 0) e = cyc;
    end
    in_good[3] = 0;
    check("cfg_dur_next_start", 32'(e - s), 10);

    // Reset in the middle of a token.
    in_good[3] = 1; cycle(); in_good[3] = 0;
    repeat (2) cycle();
    check("rst_pre_on", 32'(is_on[3]), 1);
    reset_mid();

    // Randomized traffic and config against the model.
    for (int k = 0; k < 400; k++) begin
      tick = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NCH; i++) begin
        in_good[i] = int'($urandom_range(0, 11)) - 4;
        in_bad[i]  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 8)) - 4;
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1;
        cfg_channel = 2'($urandom_range(0, 3));
        cfg_sel = 2'($urandom_range(0, 3));
        case (cfg_sel)
          2'd0: cfg_data = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(128, 255))
                                                       : 8'($urandom_range(0, 60));
          2'd1: cfg_data = 8'($urandom_range(0, 10));
          2'd2: cfg_data = 8'($urandom_range(0, 12));
          default: cfg_data = 8'($urandom_range(0, 255));
        endcase
      end
      cycle();
      cfg_we = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin in_good[i] = 0; in_bad[i] = 0; end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
